strand_scheduler: RTL and testbench

Frame sequencer and pixel-RAM read arbiter for a bank of NUM_STRANDS strand drivers. On a frame trigger it pulses start_frame to every enabled strand driver and waits until all of them are idle. During the frame it shares one synchronous pixel-RAM read port among the drivers. Each driver gets a per-strand data register holding the 24-bit word for that driver's current pixel index. It sits between the host register block, the pixel RAM and the strand_driver instances.

---
 rtl/strand_scheduler_if.sv | 39 +++
 rtl/strand_scheduler.sv | 207 ++++++++++++++++++++
 tb/tb_strand_scheduler.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/strand_scheduler_if.sv
// strand_scheduler_if
//   Groups every non-clock/reset signal of the strand scheduler.
//   slave  : the scheduler side (frame control in, strand status in,
//            RAM read port out, per-strand pixel words out).
//   master : the environment side (host, pixel RAM, strand drivers).
//   Strand s owns strand_idx[s*IDX_WIDTH +: IDX_WIDTH] and
//   strand_data[s*MEM_DATA_WIDTH +: MEM_DATA_WIDTH].
interface strand_scheduler_if #(
    parameter int NUM_STRANDS    = 4,
    parameter int SEL_WIDTH      = 2,
    parameter int IDX_WIDTH      = 16,
    parameter int MEM_DATA_WIDTH = 24
);
    logic                                  frame_trigger;
    logic [NUM_STRANDS-1:0]                strand_enable;
    logic [NUM_STRANDS-1:0]                start_frame;
    logic [NUM_STRANDS-1:0]                strand_busy;
    logic [NUM_STRANDS*IDX_WIDTH-1:0]      strand_idx;
    logic                                  mem_rd;
    logic [SEL_WIDTH+IDX_WIDTH-1:0]        mem_addr;
    logic [MEM_DATA_WIDTH-1:0]             mem_rdata;
    logic [NUM_STRANDS*MEM_DATA_WIDTH-1:0] strand_data;
    logic [NUM_STRANDS-1:0]                strand_data_valid;
    logic                                  frame_active;
    logic                                  frame_done;
    logic                                  frame_overrun;

    modport slave (
        input  frame_trigger, strand_enable, strand_busy, strand_idx, mem_rdata,
        output start_frame, mem_rd, mem_addr, strand_data, strand_data_valid,
               frame_active, frame_done, frame_overrun
    );

    modport master (
        output frame_trigger, strand_enable, strand_busy, strand_idx, mem_rdata,
        input  start_frame, mem_rd, mem_addr, strand_data, strand_data_valid,
               frame_active, frame_done, frame_overrun
    );
endinterface

// File: rtl/strand_scheduler.sv
// strand_scheduler
//   Frame sequencer plus round-robin arbiter for a shared synchronous
//   pixel-RAM read port. Each strand keeps a one-entry cache of the pixel
//   word for its current index.
// Ports
//   clk, rst : clock, asynchronous active-high reset
//   bus      : strand_scheduler_if.slave (frame control, strand status,
//              RAM read port, per-strand pixel words and valids)

// One strand's cache entry: data, cached index, index of the read in
// flight, valid and in-flight flags. Raises req_o while its word is stale.
module strand_scheduler_lane #(
    parameter int IDX_WIDTH      = 16,
    parameter int MEM_DATA_WIDTH = 24
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear_i,   // new frame accepted
    input  logic                      run_i,     // FSM in RUN
    input  logic                      active_i,  // strand enabled this frame
    input  logic                      busy_i,
    input  logic [IDX_WIDTH-1:0]      idx_i,
    input  logic                      grant_i,
    input  logic                      capture_i, // RAM data for this strand
    input  logic [MEM_DATA_WIDTH-1:0] rdata_i,
    output logic                      req_o,
    output logic [MEM_DATA_WIDTH-1:0] data_o,
    output logic                      data_valid_o
);
    logic [MEM_DATA_WIDTH-1:0] data_q;
    logic [IDX_WIDTH-1:0]      cached_idx_q;
    logic [IDX_WIDTH-1:0]      issued_idx_q;
    logic                      valid_q;
    logic                      inflight_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q       <= '0;
            cached_idx_q <= '0;
            issued_idx_q <= '0;
            valid_q      <= 1'b0;
            inflight_q   <= 1'b0;
        end else begin
            if (grant_i) begin
                issued_idx_q <= idx_i;
                inflight_q   <= 1'b1;
            end
            if (capture_i) begin
                data_q       <= rdata_i;
                cached_idx_q <= issued_idx_q;
                valid_q      <= 1'b1;
                inflight_q   <= 1'b0;
            end
            // frame start wins; no capture can coincide with it anyway
            if (clear_i) begin
                valid_q    <= 1'b0;
                inflight_q <= 1'b0;
            end
        end
    end

    assign req_o = run_i & active_i & busy_i & ~inflight_q &
                   (~valid_q | (cached_idx_q != idx_i));
    assign data_o       = data_q;
    // drops on its own when the driver moves on before the refetch lands
    assign data_valid_o = valid_q & (cached_idx_q == idx_i);
endmodule

module strand_scheduler #(
    parameter int NUM_STRANDS    = 4,
    parameter int SEL_WIDTH      = 2,
    parameter int IDX_WIDTH      = 16,
    parameter int MEM_DATA_WIDTH = 24
) (
    input  logic                clk,
    input  logic                rst,
    strand_scheduler_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, START, ARM, RUN, DONE} state_e;

    state_e                   state_q, state_d;
    logic [NUM_STRANDS-1:0]   mask_q, mask_d;
    logic [SEL_WIDTH-1:0]     ptr_q;
    logic                     mem_rd_q;
    logic [SEL_WIDTH+IDX_WIDTH-1:0] mem_addr_q;
    logic                     rd_pend_q;   // mem_rdata valid this cycle
    logic [SEL_WIDTH-1:0]     pend_sel_q;  // strand that owns it
    logic                     overrun_q;

    logic                     accept;
    logic                     run;
    logic [NUM_STRANDS-1:0]   start_frame;
    logic                     frame_active;
    logic                     frame_done;

    logic [NUM_STRANDS-1:0]                     req;
    logic [NUM_STRANDS-1:0]                     dvalid;
    logic [NUM_STRANDS-1:0][IDX_WIDTH-1:0]      idx_w;
    logic [NUM_STRANDS-1:0][MEM_DATA_WIDTH-1:0] data_w;

    logic                     gnt_vld;
    logic [SEL_WIDTH-1:0]     gnt_sel;
    logic [SEL_WIDTH-1:0]     cand;

    assign idx_w = bus.strand_idx;

    // ---------------- frame FSM ----------------
    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        accept       = 1'b0;
        start_frame  = '0;
        frame_active = (state_q != IDLE);
        frame_done   = 1'b0;
        case (state_q)
            IDLE: if (bus.frame_trigger) begin
                mask_d  = bus.strand_enable;
                state_d = (bus.strand_enable == '0) ? DONE : START;
                accept  = (bus.strand_enable != '0);
            end
            START: begin
                start_frame = mask_q;
                state_d     = ARM;
            end
            ARM:  state_d = RUN;   // driver busy shows up one cycle after start
            RUN:  if ((bus.strand_busy & mask_q) == '0) state_d = DONE;
            DONE: begin
                frame_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign run = (state_q == RUN);

    // ---------------- round-robin arbiter ----------------
    // power-of-two strand count: SEL_WIDTH-bit add wraps for free
    always_comb begin
        gnt_vld = 1'b0;
        gnt_sel = '0;
        cand    = '0;
        for (int i = 0; i < NUM_STRANDS; i++) begin
            cand = ptr_q + SEL_WIDTH'(i);
            if (!gnt_vld && req[cand]) begin
                gnt_vld = 1'b1;
                gnt_sel = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            mask_q     <= '0;
            ptr_q      <= '0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            rd_pend_q  <= 1'b0;
            pend_sel_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            overrun_q <= bus.frame_trigger & (state_q != IDLE);
            // requests only exist in RUN, so mem_rd falls as RUN is left
            mem_rd_q  <= gnt_vld;
            if (gnt_vld) begin
                mem_addr_q <= {gnt_sel, idx_w[gnt_sel]};
                ptr_q      <= gnt_sel + 1'b1;
            end
            rd_pend_q  <= mem_rd_q;
            pend_sel_q <= mem_addr_q[SEL_WIDTH+IDX_WIDTH-1 -: SEL_WIDTH];
        end
    end

    // ---------------- per-strand caches ----------------
    for (genvar s = 0; s < NUM_STRANDS; s++) begin : g_lane
        strand_scheduler_lane #(
            .IDX_WIDTH      (IDX_WIDTH),
            .MEM_DATA_WIDTH (MEM_DATA_WIDTH)
        ) u_lane (
            .clk          (clk),
            .rst          (rst),
            .clear_i      (accept),
            .run_i        (run),
            .active_i     (mask_q[s]),
            .busy_i       (bus.strand_busy[s]),
            .idx_i        (idx_w[s]),
            .grant_i      (gnt_vld && (gnt_sel == SEL_WIDTH'(s))),
            .capture_i    (rd_pend_q && (pend_sel_q == SEL_WIDTH'(s))),
            .rdata_i      (bus.mem_rdata),
            .req_o        (req[s]),
            .data_o       (data_w[s]),
            .data_valid_o (dvalid[s])
        );
    end

    assign bus.start_frame       = start_frame;
    assign bus.frame_active      = frame_active;
    assign bus.frame_done        = frame_done;
    assign bus.frame_overrun     = overrun_q;
    assign bus.mem_rd            = mem_rd_q;
    assign bus.mem_addr          = mem_addr_q;
    assign bus.strand_data       = data_w;
    assign bus.strand_data_valid = dvalid;
endmodule

// File: tb/tb_strand_scheduler.sv
// tb_strand_scheduler
//   Random frame triggers, enables, driver busy/index activity and an async
//   reset mid-frame, checked each cycle against a behavioural model of the
//   frame timeline, round-robin arbitration and per-strand caches.
module tb_strand_scheduler;
    localparam int NS = 4, SW = 2, IW = 16, DW = 24;
    localparam int NCYC = 2500;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    strand_scheduler_if #(.NUM_STRANDS(NS), .SEL_WIDTH(SW), .IDX_WIDTH(IW),
                          .MEM_DATA_WIDTH(DW)) bus();

    strand_scheduler #(.NUM_STRANDS(NS), .SEL_WIDTH(SW), .IDX_WIDTH(IW),
                       .MEM_DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] ram(input logic [SW+IW-1:0] a);
        return {6'h15, a};
    endfunction

    // ---------------- reference model state ----------------
    bit            m_in, m_fin, m_ovr;
    int            m_age, m_ptr;
    logic [NS-1:0] m_mask;
    bit            mv [NS];
    bit            mfl[NS];
    logic [IW-1:0] mci[NS];
    logic [DW-1:0] md [NS];
    bit            m_rd, m_cp;
    logic [SW-1:0] m_rd_s, m_cp_s;
    logic [IW-1:0] m_rd_i, m_cp_i;

    task automatic model_reset();
        m_in = 0; m_fin = 0; m_ovr = 0; m_age = 0; m_ptr = 0; m_mask = '0;
        m_rd = 0; m_cp = 0; m_rd_s = '0; m_cp_s = '0; m_rd_i = '0; m_cp_i = '0;
        for (int s = 0; s < NS; s++) begin
            mv[s] = 0; mfl[s] = 0; mci[s] = '0; md[s] = '0;
        end
    endtask

    // advance the model by one clock given this cycle's inputs
    task automatic model_step(input bit trig, input logic [NS-1:0] en,
                              input logic [NS-1:0] bsy, input logic [IW-1:0] ix[NS]);
        bit running, req[NS], g_ok;
        int g;
        running = m_in && !m_fin && m_age >= 3;
        for (int s = 0; s < NS; s++)
            req[s] = running && m_mask[s] && bsy[s] && !mfl[s] && (!mv[s] || mci[s] != ix[s]);
        g_ok = 0; g = 0;
        for (int off = 0; off < NS; off++)
            if (!g_ok && req[(m_ptr + off) % NS]) begin
                g_ok = 1; g = (m_ptr + off) % NS;
            end
        if (m_cp) begin
            md[m_cp_s]  = ram({m_cp_s, m_cp_i});
            mci[m_cp_s] = m_cp_i;
            mv[m_cp_s]  = 1;
            mfl[m_cp_s] = 0;
        end
        m_cp = m_rd; m_cp_s = m_rd_s; m_cp_i = m_rd_i;
        m_rd = g_ok;
        if (g_ok) begin
            m_rd_s = SW'(g); m_rd_i = ix[g]; mfl[g] = 1; m_ptr = (g + 1) % NS;
        end
        m_ovr = trig && m_in;
        if (!m_in) begin
            if (trig) begin
                m_mask = en; m_in = 1; m_age = 1; m_fin = (en == '0);
                if (en != '0)
                    for (int s = 0; s < NS; s++) begin mv[s] = 0; mfl[s] = 0; end
            end
        end else if (m_fin) begin
            m_in = 0; m_fin = 0;
        end else if (running && (bsy & m_mask) == '0) begin
            m_fin = 1;
        end else if (m_age < 3) begin
            m_age++;
        end
    endtask

    // ---------------- environment (drivers + RAM) ----------------
    int            drv_len[NS];
    logic [IW-1:0] idx[NS];
    logic [NS-1:0] bsy;
    bit            prev_rd;
    logic [SW+IW-1:0] prev_addr;
    logic [NS-1:0] starts;

    initial begin
        bit            trig;
        logic [NS-1:0] en;
        logic [IW*NS-1:0] idx_flat;
        logic [DW*NS-1:0] exp_data;
        logic [NS-1:0]    exp_dv;
        int  rst_left;
        bit  did_rst;

        bus.frame_trigger = 0; bus.strand_enable = '0; bus.strand_busy = '0;
        bus.strand_idx = '0; bus.mem_rdata = '0;
        for (int s = 0; s < NS; s++) begin drv_len[s] = 0; idx[s] = '0; end
        prev_rd = 0; prev_addr = '0; rst_left = 3; did_rst = 0;
        model_reset();

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            // reset once mid-frame while a read is on the bus
            if (!did_rst && cyc > 1200 && m_rd && !rst) begin
                did_rst = 1; rst_left = 2;
            end
            rst  = (rst_left > 0);
            if (rst_left > 0) rst_left--;
            trig = ($urandom_range(0, 11) == 0);
            en   = ($urandom_range(0, 7) == 0) ? '0 : NS'($urandom);
            for (int s = 0; s < NS; s++) begin
                bsy[s] = (drv_len[s] > 0);
                idx_flat[s*IW +: IW] = idx[s];
            end
            bus.frame_trigger = trig;
            bus.strand_enable = en;
            bus.strand_busy   = bsy;
            bus.strand_idx    = idx_flat;
            bus.mem_rdata     = prev_rd ? ram(prev_addr) : DW'($urandom);
            #1;
            if (rst) model_reset();

            for (int s = 0; s < NS; s++) begin
                exp_data[s*DW +: DW] = md[s];
                exp_dv[s] = mv[s] && (mci[s] == idx[s]);
            end
            chk("start_frame", bus.start_frame, (m_in && !m_fin && m_age == 1) ? m_mask : '0);
            chk("frame_active", bus.frame_active, m_in);
            chk("frame_done", bus.frame_done, m_fin);
            chk("frame_overrun", bus.frame_overrun, m_ovr);
            chk("mem_rd", bus.mem_rd, m_rd);
            if (m_rd) chk("mem_addr", bus.mem_addr, {m_rd_s, m_rd_i});
            chk("strand_data_valid", bus.strand_data_valid, exp_dv);
            chk("strand_data", bus.strand_data, exp_data);

            prev_rd = bus.mem_rd; prev_addr = bus.mem_addr; starts = bus.start_frame;
            if (!rst) model_step(trig, en, bsy, idx);

            // drivers: go busy the cycle after start, wander the index
            for (int s = 0; s < NS; s++) begin
                if (starts[s]) begin
                    drv_len[s] = $urandom_range(3, 30);
                    idx[s] = '0;
                end else if (drv_len[s] > 0) begin
                    drv_len[s]--;
                    case ($urandom_range(0, 5))
                        0, 1: idx[s] = idx[s] + 1'b1;
                        2:    idx[s] = IW'($urandom);
                        default: ;
                    endcase
                end else if ($urandom_range(0, 63) == 0) begin
                    drv_len[s] = $urandom_range(1, 6);  // stray busy on an idle strand
                end
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
